// File: rtl/clahe_ctrl_pkg.sv
// Shared types and geometry helpers for the CLAHE frame sequencer.
package clahe_ctrl_pkg;

  typedef enum logic [2:0] {CLEAR, READY, ACTIVE, FLUSH, CDF} state_e;

  localparam int DEF_IMG_WIDTH  = 1280;
  localparam int DEF_IMG_HEIGHT = 720;
  localparam int DEF_TILE_H_NUM = 8;
  localparam int DEF_TILE_V_NUM = 8;
  localparam int TILE_W = DEF_IMG_WIDTH / DEF_TILE_H_NUM;
  localparam int TILE_H = DEF_IMG_HEIGHT / DEF_TILE_V_NUM;

  // Elaboration-time only; never becomes hardware.
  function automatic int tile_dim(input int total, input int num);
    return total / num;
  endfunction

  function automatic int tile_num(input int h_num, input int v_num);
    return h_num * v_num;
  endfunction

endpackage

// File: rtl/clahe_tile_locator.sv
// Raster counters and the single output register stage that aligns
// hist_y/hist_href/hist_vsync with tile_idx.
module clahe_tile_locator
  import clahe_ctrl_pkg::*;
#(
  parameter int TILE_W_P      = TILE_W,
  parameter int TILE_H_P      = TILE_H,
  parameter int TILE_H_NUM    = 8,
  parameter int TILE_V_NUM    = 8,
  parameter int TILE_NUM_BITS = 6
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic [7:0]               in_y,
  input  logic                     in_href,
  input  logic                     in_vsync,
  input  logic                     frame_start,
  input  logic                     href_en,
  output logic                     href_fall,
  output logic [7:0]               hist_y,
  output logic                     hist_href,
  output logic                     hist_vsync,
  output logic [TILE_NUM_BITS-1:0] tile_idx
);
  localparam int XW = $clog2(TILE_W_P + 1);
  localparam int LW = $clog2(TILE_H_P + 1);
  localparam int CW = $clog2(TILE_H_NUM + 1);
  localparam int RW = $clog2(TILE_V_NUM + 1);

  logic                     href_q, href_rise;
  logic [XW-1:0]            pix_x_q, pix_x_d, x_cur;
  logic [CW-1:0]            col_q, col_d, col_cur;
  logic [LW-1:0]            pix_l_q, pix_l_d;
  logic [RW-1:0]            row_q, row_d, row_cur;
  logic [7:0]               hist_y_q;
  logic                     hist_href_q, hist_vsync_q;
  logic [TILE_NUM_BITS-1:0] tile_idx_q, tile_idx_d;

  assign href_rise = in_href & ~href_q;
  assign href_fall = ~in_href & href_q;

  always_comb begin
    // The pixel on a line's first cycle sits at x=0 even though the counters still hold the old line.
    x_cur   = href_rise ? '0 : pix_x_q;
    col_cur = href_rise ? '0 : col_q;
    row_cur = frame_start ? '0 : row_q;
    pix_x_d = x_cur;
    col_d   = col_cur;
    if (in_href) begin
      if (x_cur == XW'(TILE_W_P - 1)) begin
        pix_x_d = '0;
        col_d   = (col_cur == CW'(TILE_H_NUM - 1)) ? col_cur : col_cur + 1'b1;
      end else begin
        pix_x_d = x_cur + 1'b1;
      end
    end
    pix_l_d = frame_start ? '0 : pix_l_q;
    row_d   = row_cur;
    if (href_fall && !frame_start) begin
      if (pix_l_q == LW'(TILE_H_P - 1)) begin
        pix_l_d = '0;
        row_d   = (row_q == RW'(TILE_V_NUM - 1)) ? row_q : row_q + 1'b1;
      end else begin
        pix_l_d = pix_l_q + 1'b1;
      end
    end
    tile_idx_d = TILE_NUM_BITS'(row_cur) * TILE_NUM_BITS'(TILE_H_NUM) + TILE_NUM_BITS'(col_cur);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_q       <= 1'b0;
      pix_x_q      <= '0;
      col_q        <= '0;
      pix_l_q      <= '0;
      row_q        <= '0;
      hist_y_q     <= '0;
      hist_href_q  <= 1'b0;
      hist_vsync_q <= 1'b0;
      tile_idx_q   <= '0;
    end else begin
      href_q       <= in_href;
      pix_x_q      <= pix_x_d;
      col_q        <= col_d;
      pix_l_q      <= pix_l_d;
      row_q        <= row_d;
      hist_y_q     <= in_y;
      hist_href_q  <= in_href & href_en;
      hist_vsync_q <= in_vsync;
      tile_idx_q   <= tile_idx_d;
    end
  end

  assign hist_y     = hist_y_q;
  assign hist_href  = hist_href_q;
  assign hist_vsync = hist_vsync_q;
  assign tile_idx   = tile_idx_q;

endmodule

// File: rtl/clahe_frame_ctrl.sv
// CLAHE frame sequencer: ping-pong buffer FSM (clear/accumulate/flush/CDF)
// with frame dropping. Optional stats counters: CLAHE_FRAME_STATS_EN.
module clahe_frame_ctrl
  import clahe_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH     = 1280,
  parameter int IMG_HEIGHT    = 720,
  parameter int TILE_H_NUM    = 8,
  parameter int TILE_V_NUM    = 8,
  parameter int TILE_NUM_BITS = 6
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic [7:0]               in_y,
  input  logic                     in_href,
  input  logic                     in_vsync,
  output logic [7:0]               hist_y,
  output logic                     hist_href,
  output logic                     hist_vsync,
  output logic [TILE_NUM_BITS-1:0] tile_idx,
  output logic                     ping_pong_flag,
  output logic                     clear_start,
  input  logic                     clear_done,
  input  logic                     frame_hist_done,
  output logic                     cdf_start,
  input  logic                     cdf_done,
  output logic                     buf_ready,
  output logic                     frame_drop,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               drop_cnt
);
  localparam int LNW = $clog2(IMG_HEIGHT + 1);

  state_e         state_q, state_d;
  logic           vs_q, vs_rise, href_fall, accept, drop;
  logic           pp_q, pp_d, clr_pend_q, clr_pend_d;
  logic           clear_start_q, clear_start_d, cdf_start_q, cdf_start_d;
  logic           buf_ready_q, buf_ready_d, frame_drop_q, frame_drop_d;
  logic           href_en_q, href_en_d;
  logic [LNW-1:0] line_cnt_q, line_cnt_d;

  clahe_tile_locator #(
    .TILE_W_P     (tile_dim(IMG_WIDTH, TILE_H_NUM)),
    .TILE_H_P     (tile_dim(IMG_HEIGHT, TILE_V_NUM)),
    .TILE_H_NUM   (TILE_H_NUM),
    .TILE_V_NUM   (TILE_V_NUM),
    .TILE_NUM_BITS(TILE_NUM_BITS)
  ) u_loc (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .in_y       (in_y),
    .in_href    (in_href),
    .in_vsync   (in_vsync),
    .frame_start(accept),
    .href_en    (href_en_q),
    .href_fall  (href_fall),
    .hist_y     (hist_y),
    .hist_href  (hist_href),
    .hist_vsync (hist_vsync),
    .tile_idx   (tile_idx)
  );

  assign vs_rise = in_vsync & ~vs_q;

  always_comb begin
    state_d       = state_q;
    pp_d          = pp_q;
    clr_pend_d    = 1'b0;
    clear_start_d = clr_pend_q;
    cdf_start_d   = 1'b0;
    href_en_d     = href_en_q;
    line_cnt_d    = line_cnt_q;
    accept        = 1'b0;
    case (state_q)
      CLEAR:  if (clear_done) begin
                if (vs_rise) accept = 1'b1;
                else         state_d = READY;
              end
      READY:  if (vs_rise) accept = 1'b1;
      ACTIVE: if (vs_rise) begin
                state_d   = FLUSH;
                href_en_d = 1'b0;
              end else if (href_fall) begin
                line_cnt_d = line_cnt_q + 1'b1;
                if (line_cnt_q == LNW'(IMG_HEIGHT - 1)) begin
                  state_d   = FLUSH;
                  href_en_d = 1'b0;
                end
              end
      FLUSH:  if (frame_hist_done) begin
                state_d     = CDF;
                cdf_start_d = 1'b1;
              end
      CDF:    if (cdf_done) begin
                state_d    = CLEAR;
                pp_d       = ~pp_q;
                clr_pend_d = 1'b1;
              end
      default: state_d = CLEAR;
    endcase
    drop = vs_rise & ~accept;
    if (accept) begin
      state_d    = ACTIVE;
      href_en_d  = 1'b1;
      line_cnt_d = '0;
    end
    if (drop) href_en_d = 1'b0;
    frame_drop_d = drop;
    buf_ready_d  = (state_d == READY);
  end

  // clr_pend resets high so the first cycle out of reset requests a clear.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEAR;
      vs_q          <= 1'b0;
      pp_q          <= 1'b0;
      clr_pend_q    <= 1'b1;
      clear_start_q <= 1'b0;
      cdf_start_q   <= 1'b0;
      buf_ready_q   <= 1'b0;
      frame_drop_q  <= 1'b0;
      href_en_q     <= 1'b0;
      line_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= in_vsync;
      pp_q          <= pp_d;
      clr_pend_q    <= clr_pend_d;
      clear_start_q <= clear_start_d;
      cdf_start_q   <= cdf_start_d;
      buf_ready_q   <= buf_ready_d;
      frame_drop_q  <= frame_drop_d;
      href_en_q     <= href_en_d;
      line_cnt_q    <= line_cnt_d;
    end
  end

  assign ping_pong_flag = pp_q;
  assign clear_start    = clear_start_q;
  assign cdf_start      = cdf_start_q;
  assign buf_ready      = buf_ready_q;
  assign frame_drop     = frame_drop_q;

`ifdef CLAHE_FRAME_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = accept ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_clahe_frame_ctrl.sv
// Bench for clahe_frame_ctrl: 64x32 image, 8x8 tiles, directed scenarios then random frames.
module tb_clahe_frame_ctrl;
  localparam int W = 64, H = 32, HN = 8, VN = 8, TB = 6;
  localparam int TW = W / HN, TH = H / VN;
  localparam int P_CLEAR = 0, P_READY = 1, P_ACTIVE = 2, P_FLUSH = 3, P_CDF = 4;
`ifdef CLAHE_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic pclk = 1'b0, rst_n = 1'b1;
  logic [7:0] in_y = '0;
  logic in_href = 1'b0, in_vsync = 1'b0;
  logic clear_done = 1'b0, frame_hist_done = 1'b0, cdf_done = 1'b0;
  logic [7:0] hist_y, drop_cnt;
  logic hist_href, hist_vsync, ping_pong_flag, clear_start, cdf_start, buf_ready, frame_drop;
  logic [TB-1:0] tile_idx;
  logic [15:0] frame_cnt;

  always #5 pclk = ~pclk;

  clahe_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TILE_H_NUM(HN), .TILE_V_NUM(VN),
                     .TILE_NUM_BITS(TB)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_y(in_y), .in_href(in_href), .in_vsync(in_vsync),
    .hist_y(hist_y), .hist_href(hist_href), .hist_vsync(hist_vsync), .tile_idx(tile_idx),
    .ping_pong_flag(ping_pong_flag), .clear_start(clear_start), .clear_done(clear_done),
    .frame_hist_done(frame_hist_done), .cdf_start(cdf_start), .cdf_done(cdf_done),
    .buf_ready(buf_ready), .frame_drop(frame_drop), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));

  // Reference model: frame-level rules, tile from plain division of raster position.
  int m_ph, m_line, m_x, e_tile;
  int lit_exp = -1, lit_q = -1;
  bit m_buf, m_pend, m_vsp, m_hrp, m_en;
  logic [7:0] e_y, m_dc;
  logic [15:0] m_fc;
  logic e_href, e_vs, e_clr, e_cdf, e_rdy, e_drop;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_CLEAR; m_buf <= 0; m_pend <= 1; m_vsp <= 0; m_hrp <= 0; m_en <= 0;
      m_line <= 0; m_x <= 0; e_tile <= 0; e_y <= 0; e_href <= 0; e_vs <= 0;
      e_clr <= 0; e_cdf <= 0; e_rdy <= 0; e_drop <= 0; m_fc <= 0; m_dc <= 0; lit_q <= -1;
    end else begin : step
      bit rise, acc, drp, fall;
      int ph, x, ln, r, c;
      rise = in_vsync && !m_vsp;
      acc  = rise && (m_ph == P_READY || (m_ph == P_CLEAR && clear_done));
      drp  = rise && !acc;
      fall = !in_href && m_hrp;
      ln   = acc ? 0 : m_line;
      x    = (in_href && !m_hrp) ? 0 : m_x;
      r = ln / TH; if (r > VN - 1) r = VN - 1;
      c = x / TW;  if (c > HN - 1) c = HN - 1;
      ph = m_ph;
      e_cdf <= 0;
      m_pend <= 0;
      case (m_ph)
        P_CLEAR:  if (clear_done) ph = P_READY;
        P_ACTIVE: if (rise || (fall && ln + 1 == H)) ph = P_FLUSH;
        P_FLUSH:  if (frame_hist_done) begin ph = P_CDF; e_cdf <= 1; end
        P_CDF:    if (cdf_done) begin ph = P_CLEAR; m_buf <= !m_buf; m_pend <= 1; end
        default: ;
      endcase
      if (acc) ph = P_ACTIVE;
      m_en   <= acc ? 1'b1 : (drp || (m_ph == P_ACTIVE && ph == P_FLUSH)) ? 1'b0 : m_en;
      e_tile <= r * HN + c;
      e_href <= in_href && m_en;
      e_y    <= in_y;
      e_vs   <= in_vsync;
      e_clr  <= m_pend;
      e_rdy  <= (ph == P_READY);
      e_drop <= drp;
      if (STATS) begin
        m_fc <= m_fc + (acc ? 16'd1 : 16'd0);
        m_dc <= (drp && m_dc != 8'hff) ? m_dc + 8'd1 : m_dc;
      end
      m_line <= fall ? ln + 1 : ln;
      m_x    <= in_href ? x + 1 : x;
      m_ph   <= ph;
      m_vsp  <= in_vsync;
      m_hrp  <= in_href;
      lit_q  <= lit_exp;
    end
  end

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc_check();
    chk("hist_y", 32'(hist_y), 32'(e_y));
    chk("hist_href", 32'(hist_href), 32'(e_href));
    chk("hist_vsync", 32'(hist_vsync), 32'(e_vs));
    chk("ping_pong_flag", 32'(ping_pong_flag), 32'(m_buf));
    chk("clear_start", 32'(clear_start), 32'(e_clr));
    chk("cdf_start", 32'(cdf_start), 32'(e_cdf));
    chk("buf_ready", 32'(buf_ready), 32'(e_rdy));
    chk("frame_drop", 32'(frame_drop), 32'(e_drop));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
    if (e_href) chk("tile_idx", 32'(tile_idx), 32'(e_tile));
    if (lit_q >= 0) chk("tile_idx_literal", 32'(tile_idx), 32'(lit_q));
  endtask

  // Every cycle is compared at the falling edge; inputs change 1 unit after the rising edge.
  task automatic tick();
    @(negedge pclk);
    cyc_check();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_lines(input int nl, input int wl, input bit probe);
    for (int l = 0; l < nl; l++) begin
      for (int x = 0; x < wl; x++) begin
        in_href = 1'b1;
        in_y = 8'($urandom);
        lit_exp = -1;
        if (probe && x == 9 && l == 5) lit_exp = 9;
        if (probe && x == 63 && l == 31) lit_exp = 63;
        tick();
      end
      in_href = 1'b0;
      lit_exp = -1;
      repeat ($urandom_range(2, 5)) tick();
    end
  endtask

  task automatic vs_pulse();
    in_vsync = 1'b1; tick(); tick();
    in_vsync = 1'b0; tick(); tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset clear_start", 32'(clear_start), 0);
    chk("reset buf_ready", 32'(buf_ready), 0);
    chk("reset ping_pong", 32'(ping_pong_flag), 0);
    rst_n = 1'b1;
    tick();
    chk("clear_start cycle1", 32'(clear_start), 1);
    chk("ping_pong cycle1", 32'(ping_pong_flag), 0);
    tick();
    chk("clear_start one-shot", 32'(clear_start), 0);
    repeat (4) tick();
    chk("buf_ready before clear_done", 32'(buf_ready), 0);
    clear_done = 1'b1; tick(); clear_done = 1'b0;
    chk("buf_ready after clear_done", 32'(buf_ready), 1);
    repeat (3) tick();

    // Frame 1: full accepted frame with tile probes.
    in_vsync = 1'b1; tick();
    chk("accept no drop", 32'(frame_drop), 0);
    tick(); in_vsync = 1'b0; repeat (3) tick();
    send_lines(H, W, 1'b1);
    repeat (5) tick();
    frame_hist_done = 1'b1; tick(); frame_hist_done = 1'b0;
    chk("cdf_start after hist_done", 32'(cdf_start), 1);
    tick();

    // Frame 2: arrives during CDF and must be dropped.
    in_vsync = 1'b1; tick();
    chk("drop in CDF", 32'(frame_drop), 1);
    chk("drop_cnt", 32'(drop_cnt), STATS ? 1 : 0);
    tick(); in_vsync = 1'b0;
    send_lines(H, W, 1'b0);
    cdf_done = 1'b1; tick(); cdf_done = 1'b0;
    chk("ping_pong flips", 32'(ping_pong_flag), 1);
    chk("clear_start waits", 32'(clear_start), 0);
    tick();
    chk("clear_start after flip", 32'(clear_start), 1);
    repeat (3) tick();

    // Frame 3: clear_done coincident with vsync rise, then reset mid-line.
    clear_done = 1'b1; in_vsync = 1'b1; tick(); clear_done = 1'b0;
    chk("coincident no drop", 32'(frame_drop), 0);
    chk("coincident frame_cnt", 32'(frame_cnt), STATS ? 2 : 0);
    tick(); in_vsync = 1'b0; repeat (3) tick();
    send_lines(10, W, 1'b0);
    for (int x = 0; x < 20; x++) begin in_href = 1'b1; in_y = 8'($urandom); tick(); end
    chk("hist_href mid-line", 32'(hist_href), 1);
    rst_n = 1'b0; #1;
    chk("rst hist_href", 32'(hist_href), 0);
    chk("rst hist_y", 32'(hist_y), 0);
    chk("rst tile_idx", 32'(tile_idx), 0);
    chk("rst ping_pong", 32'(ping_pong_flag), 0);
    chk("rst frame_cnt", 32'(frame_cnt), 0);
    in_href = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; tick();
    chk("restart clear_start", 32'(clear_start), 1);
    chk("restart ping_pong", 32'(ping_pong_flag), 0);

    // Random frames: handshake latencies, early/short frames, long lines.
    for (int f = 0; f < 6; f++) begin
      int wl;
      repeat ($urandom_range(1, 6)) tick();
      if ($urandom_range(0, 3) == 0) vs_pulse();
      if ($urandom_range(0, 2) == 0) begin
        clear_done = 1'b1; in_vsync = 1'b1; tick(); clear_done = 1'b0;
        tick(); in_vsync = 1'b0; tick();
      end else begin
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        vs_pulse();
      end
      wl = ($urandom_range(0, 3) == 0) ? W + 8 : W;
      if ($urandom_range(0, 3) == 0) begin
        send_lines($urandom_range(1, 8), wl, 1'b0);
        vs_pulse();
      end else begin
        send_lines(H, wl, 1'b0);
      end
      repeat ($urandom_range(1, 8)) tick();
      if ($urandom_range(0, 2) == 0) vs_pulse();
      frame_hist_done = 1'b1; tick(); frame_hist_done = 1'b0;
      repeat ($urandom_range(1, 6)) tick();
      cdf_done = 1'b1; tick(); cdf_done = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/clahe_frame_ctrl.md
# clahe_frame_ctrl

Frame-level sequencer for the CLAHE histogram path. It sits between the camera timing inputs and the histogram-statistics / banked-RAM pair, and derives the per-pixel tile index from raster counters. It owns the ping-pong buffer select and walks each buffer through clear, accumulate, histogram flush and CDF handoff. Frames that arrive before the next buffer is ready are dropped cleanly instead of corrupting a histogram.

## Interface
- IMG_WIDTH, 1280, active pixels per line; must be divisible by TILE_H_NUM
- IMG_HEIGHT, 720, active lines per frame; must be divisible by TILE_V_NUM
- TILE_H_NUM, 8, tile columns
- TILE_V_NUM, 8, tile rows
- TILE_NUM_BITS, 6, width of tile_idx; 2**TILE_NUM_BITS >= TILE_H_NUM*TILE_V_NUM
- pclk  in  1  pixel clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_y  in  8  luma pixel
- in_href  in  1  line-valid
- in_vsync  in  1  frame sync; a rising edge marks frame start
- hist_y  out  8  registered in_y, aligned with tile_idx
- hist_href  out  1  registered in_href, gated by frame acceptance
- hist_vsync  out  1  registered in_vsync, never gated
- tile_idx  out  TILE_NUM_BITS  tile of the pixel on hist_y
- ping_pong_flag  out  1  buffer the histogram is writing
- clear_start  out  1  one-cycle pulse requesting a clear of buffer ping_pong_flag
- clear_done  in  1  one-cycle clear-complete pulse
- frame_hist_done  in  1  one-cycle pulse: histogram writes for the frame have drained
- cdf_start  out  1  one-cycle pulse; CDF may process buffer ping_pong_flag
- cdf_done  in  1  one-cycle CDF-complete pulse
- buf_ready  out  1  level: the next frame will be accepted
- frame_drop  out  1  one-cycle pulse when a frame is rejected
- frame_cnt  out  16  accepted frames (see Configuration)
- drop_cnt  out  8  dropped frames, saturating (see Configuration)

## Operation
- FSM states: CLEAR, READY, ACTIVE, FLUSH, CDF.
- Reset state is CLEAR. clear_start pulses on the first cycle after reset deasserts.
- CLEAR: wait for clear_done, then go to READY. buf_ready=1 only in READY.
- READY: a vsync rising edge moves the FSM to ACTIVE. It also clears the raster counters and enables hist_href for this frame.
- ACTIVE: count lines on the falling edge of in_href. When the line count reaches IMG_HEIGHT, stop gating hist_href and go to FLUSH.
- FLUSH: wait for frame_hist_done. Then pulse cdf_start and go to CDF.
- CDF: wait for cdf_done. Then toggle ping_pong_flag, pulse clear_start the next cycle, and go to CLEAR.
- A vsync rising edge in any state other than READY:
  - the frame is dropped: frame_drop pulses and hist_href stays 0 until the next accepted frame;
  - the FSM state is unaffected.
- Simultaneous events:
  - clear_done and a vsync rise in the same cycle: the frame is accepted.
  - A vsync rise in ACTIVE: treated as a short frame. The FSM moves to FLUSH and that vsync is counted as a drop.
- Raster counters:
  - pix_x counts 0..TILE_W-1 with tile column col; pix_l counts 0..TILE_H-1 with tile row row.
  - TILE_W = IMG_WIDTH/TILE_H_NUM, TILE_H = IMG_HEIGHT/TILE_V_NUM. No dividers.
  - The x counters reset on the rising edge of in_href and advance while in_href=1. Column saturates at TILE_H_NUM-1 if a line is too long.
  - Row saturates at TILE_V_NUM-1.
- tile_idx = row*TILE_H_NUM + col. Constant multiply only.

## Timing
- hist_y, hist_href, hist_vsync and tile_idx share one register stage: latency 1 cycle from the inputs.
- cdf_start asserts 1 cycle after frame_hist_done is sampled. ping_pong_flag toggles 1 cycle after cdf_done; clear_start follows 1 cycle after the toggle.
- Reset values of all outputs: 0.
- Asserting rst_n low mid-operation aborts any frame immediately. On release, the FSM restarts in CLEAR on buffer 0.

## Configuration
- CLAHE_FRAME_STATS_EN defined: frame_cnt increments on each accepted frame (wraps at 16 bits). drop_cnt increments on each frame_drop and saturates at 255.
- Undefined: the counters are not built, and frame_cnt and drop_cnt are tied to 0. All other behaviour is identical.

## Structure
- The shared package clahe_ctrl_pkg holds:
  - the FSM state enum;
  - localparams TILE_W and TILE_H, plus a TILE_NUM function.
- One sub-module, clahe_tile_locator: the raster counters and the tile_idx/output register stage. The FSM stays in clahe_frame_ctrl.

## Test plan
Bench configuration: IMG_WIDTH=64, IMG_HEIGHT=32, 8x8 tiles, giving 8x4-pixel tiles.
- Reset release -> clear_start pulses on cycle 1 with ping_pong_flag=0; buf_ready=1 only after clear_done.
- Full frame -> pixel (x=9, line=5) gives tile_idx=9; pixel (63, 31) gives tile_idx=63; hist_href output matches in_href delayed by 1 cycle.
- frame_hist_done, then cdf_done -> cdf_start 1 cycle after frame_hist_done; ping_pong_flag flips to 1; clear_start 1 cycle after the flip.
- Vsync rise while in CDF -> frame_drop pulses, hist_href stays 0 for that whole frame, drop_cnt=1 (with CLAHE_FRAME_STATS_EN).
- clear_done coincident with a vsync rise -> frame accepted, frame_cnt increments, no frame_drop.
- rst_n pulsed low mid-line during ACTIVE -> all outputs 0 immediately; the FSM restarts in CLEAR with ping_pong_flag=0.
